sr_hypot_unit: RTL and testbench

Multi-cycle hypotenuse engine for the schoolRISCV single-cycle core. It computes floor(sqrt(a² + b²)) for two 8-bit operands taken from rs1[7:0] and rs2[7:0] of the custom HYPO instruction. It has no adder of its own: it borrows the core ALU through an operand/opcode mux and holds the PC through `busy` until the 9-bit result is ready for register write-back.

---
 rtl/sr_hypot_unit_pkg.sv | 25 ++
 rtl/sr_hypot_unit.sv | 171 +++++++++++++++++
 tb/tb_sr_hypot_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_hypot_unit_pkg.sv
// ============================================================================
// Module : sr_hypot_unit_pkg
// Brief  : Shared ALU opcodes and datapath widths for the hypotenuse engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sr_hypot_unit_pkg;

    localparam int XLEN     = 32;
    localparam int OP_W     = 8;
    localparam int ROOT_W   = 9;

    // Opcode values mirror sr_cpu.vh so the core ALU decodes them unchanged
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SRL  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam logic [XLEN-1:0] ROOT_BIT_INIT = 32'h0001_0000;

endpackage

`default_nettype wire

// File: rtl/sr_hypot_unit.sv
// ============================================================================
// Module : sr_hypot_unit
// Brief  : floor(sqrt(a^2+b^2)) using the core ALU via an operand/opcode mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_hypot_unit
    import sr_hypot_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic [XLEN-1:0]     aluResult,
    output logic [2:0]          aluOper,
    output logic [XLEN-1:0]     aluSrcA,
    output logic [XLEN-1:0]     aluSrcB,
    output logic [ROOT_W-1:0]   result,
    output logic                busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SQ     = 3'd1;
    localparam logic [2:0] S_RT_CMP = 3'd2;
    localparam logic [2:0] S_RT_SUB = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_res;
    logic [XLEN-1:0]    r_bit;
    logic [3:0]         r_i;
    logic               r_lt;
    logic [ROOT_W-1:0]  r_result;

    logic [OP_W-1:0]    w_x;
    logic [2:0]         w_k;
    logic [XLEN-1:0]    w_term;
    logic [XLEN-1:0]    w_cand;
    logic [XLEN-1:0]    w_res_shr;
    logic [XLEN-1:0]    w_res_new;
    logic               w_last;

    // Shift-add square: i<8 walks the bits of a, i>=8 the bits of b
    assign w_x       = r_i[3] ? r_b : r_a;
    assign w_k       = r_i[2:0];
    assign w_term    = w_x[w_k] ? ({{(XLEN-OP_W){1'b0}}, w_x} << w_k) : '0;

    // res and bit never overlap, so OR is the same as the textbook add
    assign w_cand    = r_res | r_bit;
    assign w_res_shr = r_res >> 1;
    assign w_res_new = r_lt ? w_res_shr : (w_res_shr | r_bit);
    assign w_last    = (r_bit == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next_state = S_SQ;
            S_SQ:     if (r_i == 4'd15) w_next_state = S_RT_CMP;
            S_RT_CMP: w_next_state = S_RT_SUB;
            S_RT_SUB: w_next_state = w_last ? S_DONE : S_RT_CMP;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        aluOper = ALU_ADD;
        aluSrcA = '0;
        aluSrcB = '0;
        busy    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = start;
            end
            S_SQ: begin
                aluSrcA = r_acc;
                aluSrcB = w_term;
                busy    = 1'b1;
            end
            S_RT_CMP: begin
                aluOper = ALU_SLTU;
                aluSrcA = r_rem;
                aluSrcB = w_cand;
                busy    = 1'b1;
            end
            S_RT_SUB: begin
                aluOper = ALU_SUB;
                aluSrcA = r_rem;
                aluSrcB = w_cand;
                busy    = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        // The PC must be free to move as soon as reset is asserted
        busy = busy & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_res    <= '0;
            r_bit    <= '0;
            r_i      <= '0;
            r_lt     <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_rem <= '0;
                        r_res <= '0;
                        r_bit <= '0;
                    end
                end
                S_SQ: begin
                    r_acc <= aluResult;
                    r_i   <= r_i + 4'd1;
                    if (r_i == 4'd15) begin
                        r_rem <= aluResult;
                        r_res <= '0;
                        r_bit <= ROOT_BIT_INIT;
                    end
                end
                S_RT_CMP: begin
                    r_lt <= aluResult[0];
                end
                S_RT_SUB: begin
                    if (!r_lt) begin
                        r_rem <= aluResult;
                    end
                    r_res <= w_res_new;
                    r_bit <= r_bit >> 2;
                    if (w_last) begin
                        r_result <= w_res_new[ROOT_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sr_hypot_unit.sv
// ============================================================================
// Module : tb_sr_hypot_unit
// Brief  : Bench for sr_hypot_unit with a behavioural ALU and reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sr_hypot_unit;
    import sr_hypot_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] aluResult;
    logic [2:0]  aluOper;
    logic [31:0] aluSrcA;
    logic [31:0] aluSrcB;
    logic [8:0]  result;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    sr_hypot_unit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .aluResult (aluResult),
        .aluOper   (aluOper),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's purely combinational ALU
    always_comb begin
        aluResult = '0;
        case (aluOper)
            ALU_ADD:  aluResult = aluSrcA + aluSrcB;
            ALU_SUB:  aluResult = aluSrcA - aluSrcB;
            ALU_SLTU: aluResult = {31'd0, (aluSrcA < aluSrcB)};
            default:  aluResult = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      nm, act, act, exp, exp, $time);
    endtask

    // Reference model: expected ALU traffic per cycle offset from T, plus the root
    logic [2:0]  exp_op [0:35];
    logic [31:0] exp_sa [0:35];
    logic [31:0] exp_sb [0:35];
    int          m_root;
    int          m_off;
    int          m_res;

    task automatic build_model(input logic [7:0] av, input logic [7:0] bv);
        int acc, rem, res, bitv, cand, x, k, term;
        exp_op[0] = ALU_ADD; exp_sa[0] = 0; exp_sb[0] = 0;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            x    = (i < 8) ? int'(av) : int'(bv);
            k    = i % 8;
            term = ((x >> k) & 1) ? x * (1 << k) : 0;
            exp_op[i+1] = ALU_ADD; exp_sa[i+1] = acc; exp_sb[i+1] = term;
            acc += term;
        end
        rem = acc; res = 0; bitv = 65536;
        for (int j = 0; j < 9; j++) begin
            cand = res + bitv;
            exp_op[17+2*j] = ALU_SLTU; exp_sa[17+2*j] = rem; exp_sb[17+2*j] = cand;
            exp_op[18+2*j] = ALU_SUB;  exp_sa[18+2*j] = rem; exp_sb[18+2*j] = cand;
            if (rem >= cand) begin
                rem -= cand;
                res = res / 2 + bitv;
            end else begin
                res = res / 2;
            end
            bitv /= 4;
        end
        exp_op[35] = ALU_ADD; exp_sa[35] = 0; exp_sb[35] = 0;
        m_root = 0;
        while ((m_root + 1) * (m_root + 1) <= acc) m_root++;
    endtask

    initial begin
        m_off = -1;
        m_res = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_off = -1;
            m_res = 0;
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_op", {29'd0, aluOper}, {29'd0, ALU_ADD});
            chk("rst_srcA", aluSrcA, 0);
            chk("rst_srcB", aluSrcB, 0);
            chk("rst_result", {23'd0, result}, 0);
        end else begin
            if (m_off < 0 && start) begin
                m_off = 0;
                build_model(a, b);
            end
            if (m_off < 0) begin
                chk("idle_busy", {31'd0, busy}, 0);
                chk("idle_op", {29'd0, aluOper}, {29'd0, ALU_ADD});
                chk("idle_srcA", aluSrcA, 0);
                chk("idle_srcB", aluSrcB, 0);
            end else begin
                if (m_off == 35) m_res = m_root;
                chk($sformatf("op@%0d", m_off), {29'd0, aluOper}, {29'd0, exp_op[m_off]});
                chk($sformatf("srcA@%0d", m_off), aluSrcA, exp_sa[m_off]);
                chk($sformatf("srcB@%0d", m_off), aluSrcB, exp_sb[m_off]);
                chk($sformatf("busy@%0d", m_off), {31'd0, busy}, (m_off < 35) ? 1 : 0);
            end
            chk("result_hold", {23'd0, result}, m_res);
            if (m_off >= 0) m_off = (m_off == 35) ? -1 : m_off + 1;
        end
    end

    task automatic run_hypo(input logic [7:0] av, input logic [7:0] bv,
                            input int sum, input int root, input bit hold);
        int  busy_n;
        bit  seen_cmp;
        bit  done;
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        busy_n = 0; seen_cmp = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (aluOper == ALU_SLTU && !seen_cmp) begin
                seen_cmp = 1;
                chk($sformatf("sum(%0d,%0d)", av, bv), aluSrcA, sum);
            end
            if (!busy) begin
                done = 1;
                chk($sformatf("root(%0d,%0d)", av, bv), {23'd0, result}, root);
                chk($sformatf("busy_len(%0d,%0d)", av, bv), busy_n, 35);
            end else if (c == 0 && !hold) begin
                // Drop start and scramble operands: the capture must already be frozen
                @(posedge clk); #1;
                start = 1'b0; a = ~av; b = ~bv;
            end
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL timeout(%0d,%0d): busy never fell, got busy=%0d expected 0", av, bv, busy);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        a = 8'd7; b = 8'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nostart_busy", {31'd0, busy}, 0);
            chk("nostart_result", {23'd0, result}, 0);
        end

        run_hypo(8'd3, 8'd4, 25, 5, 1'b1);
        idle(3);
        run_hypo(8'd255, 8'd255, 130050, 360, 1'b0);
        idle(2);
        run_hypo(8'd255, 8'd0, 65025, 255, 1'b0);
        idle(2);
        run_hypo(8'd0, 8'd0, 0, 0, 1'b0);
        idle(2);

        run_hypo(8'd1, 8'd1, 2, 1, 1'b1);
        run_hypo(8'd5, 8'd12, 169, 13, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of the root phase
        @(posedge clk); #1;
        a = 8'd9; b = 8'd12; start = 1'b1;
        repeat (21) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 0);
        chk("async_rst_result", {23'd0, result}, 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_hypo(8'd6, 8'd8, 100, 10, 1'b0);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
